// File: rtl/uart_hex_loader.sv
// Serial program loader: parses ASCII hex from the UART into 32-bit words,
// writes them to instruction memory and answers every byte with one response.
module uart_hex_loader #(
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [7:0]        rx_dout,
   input  logic              rx_rdy,
   output logic              rx_rdy_clr,
   output logic [7:0]        tx_din,
   output logic              tx_wr_en,
   input  logic              tx_busy,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [ADDR_W:0]   word_count,
   output logic              load_done,
   output logic              err
);

   typedef enum logic [1:0] {IDLE, DECODE, TXWAIT, GAP} state_t;

   localparam logic [ADDR_W:0]   CAP      = (ADDR_W+1)'(1) << ADDR_W;
   localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};

   localparam logic [7:0] CH_CLEAR = 8'h58;
   localparam logic [7:0] CH_END   = 8'h2E;
   localparam logic [7:0] CH_OVF   = 8'h21;
   localparam logic [7:0] CH_BAD   = 8'h3F;
   localparam logic [7:0] CH_OK    = 8'h4B;

   state_t              state_q;
   logic [7:0]          byte_q;
   logic [2:0]          nib_q;
   logic [31:0]         wdata_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [ADDR_W:0]     count_q;
   logic                done_q;
   logic                err_q;
   logic                we_q;
   logic                clr_q;
   logic [7:0]          txd_q;

   logic                is_hex_d;
   logic                is_ign_d;
   logic [3:0]          nib_d;

   always_comb begin
      is_hex_d = 1'b0;
      is_ign_d = 1'b0;
      nib_d    = 4'h0;
      if (byte_q >= 8'h30 && byte_q <= 8'h39) begin
         is_hex_d = 1'b1;
         nib_d    = byte_q[3:0];
      end else if ((byte_q >= 8'h41 && byte_q <= 8'h46) ||
                   (byte_q >= 8'h61 && byte_q <= 8'h66)) begin
         is_hex_d = 1'b1;
         nib_d    = byte_q[3:0] + 4'd9;
      end
      if (byte_q == 8'h0D || byte_q == 8'h0A || byte_q == 8'h20)
         is_ign_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         byte_q  <= 8'h00;
         nib_q   <= 3'd0;
         wdata_q <= 32'h0;
         addr_q  <= '0;
         count_q <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         we_q    <= 1'b0;
         clr_q   <= 1'b0;
         txd_q   <= 8'h00;
      end else begin
         clr_q <= 1'b0;
         we_q  <= 1'b0;
         // Address/count advance the cycle after the write strobe.
         if (we_q) begin
            count_q <= count_q + (ADDR_W+1)'(1);
            if (addr_q != ADDR_MAX)
               addr_q <= addr_q + ADDR_W'(1);
         end
         case (state_q)
            IDLE: begin
               if (rx_rdy && !tx_busy) begin
                  byte_q  <= rx_dout;
                  clr_q   <= 1'b1;
                  state_q <= DECODE;
               end
            end
            DECODE: begin
               state_q <= TXWAIT;
               txd_q   <= byte_q;
               if (byte_q == CH_CLEAR) begin
                  nib_q   <= 3'd0;
                  wdata_q <= 32'h0;
                  addr_q  <= '0;
                  count_q <= '0;
                  done_q  <= 1'b0;
                  err_q   <= 1'b0;
               end else if (done_q) begin
                  txd_q <= CH_OVF;
               end else if (is_hex_d) begin
                  wdata_q <= {wdata_q[27:0], nib_d};
                  nib_q   <= nib_q + 3'd1;
                  if (nib_q == 3'd7) begin
                     if (count_q < CAP) begin
                        we_q <= 1'b1;
                     end else begin
                        err_q <= 1'b1;
                        txd_q <= CH_OVF;
                     end
                  end
               end else if (is_ign_d) begin
                  txd_q <= byte_q;
               end else if (byte_q == CH_END && nib_q == 3'd0) begin
                  done_q <= 1'b1;
                  txd_q  <= CH_OK;
               end else begin
                  err_q   <= 1'b1;
                  nib_q   <= 3'd0;
                  wdata_q <= 32'h0;
                  txd_q   <= CH_BAD;
               end
            end
            TXWAIT: begin
               if (!tx_busy)
                  state_q <= GAP;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Strobe is combinational so it can fire in the first TXWAIT cycle.
   assign tx_wr_en   = (state_q == TXWAIT) && !tx_busy;
   assign tx_din     = txd_q;
   assign rx_rdy_clr = clr_q;
   assign mem_we     = we_q;
   assign mem_addr   = addr_q;
   assign mem_wdata  = wdata_q;
   assign word_count = count_q;
   assign load_done  = done_q;
   assign err        = err_q;

endmodule

// File: tb/tb_uart_hex_loader.sv
// Directed bench for uart_hex_loader with a 4-word memory to reach overflow.
module tb_uart_hex_loader;

   localparam int AW = 2;

   logic          clk;
   logic          rst_n;
   logic [7:0]    rx_dout;
   logic          rx_rdy;
   logic          rx_rdy_clr;
   logic [7:0]    tx_din;
   logic          tx_wr_en;
   logic          tx_busy;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic [AW:0]   word_count;
   logic          load_done;
   logic          err;

   uart_hex_loader #(.ADDR_W(AW)) dut (
      .clk(clk), .rst_n(rst_n), .rx_dout(rx_dout), .rx_rdy(rx_rdy),
      .rx_rdy_clr(rx_rdy_clr), .tx_din(tx_din), .tx_wr_en(tx_wr_en),
      .tx_busy(tx_busy), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .word_count(word_count),
      .load_done(load_done), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  b;
      logic [7:0]  resp;
      bit          we;
      logic [31:0] wd;
      logic [AW:0] wc;
      bit          e;
      bit          done;
   } vec_t;

   vec_t vecs[$];
   int passed = 0;
   int total  = 0;

   logic [7:0]    got_resp;
   int            we_cnt;
   int            clr_cnt;
   logic [31:0]   we_data;
   logic [AW-1:0] we_addr;
   bit            got;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic add(input logic [7:0] b, input logic [7:0] r, input bit we,
                      input logic [31:0] wd, input int wc, input bit e, input bit d);
      vec_t v;
      v.b = b; v.resp = r; v.we = we; v.wd = wd;
      v.wc = wc[AW:0]; v.e = e; v.done = d;
      vecs.push_back(v);
   endtask

   task automatic add_str(input string s, input int wc, input bit e);
      for (int i = 0; i < s.len(); i++)
         add(s[i], s[i], 1'b0, 32'h0, wc, e, 1'b0);
   endtask

   // Present one byte, follow the handshake and capture everything it causes.
   task automatic send_byte(input logic [7:0] b);
      rx_dout = b;
      rx_rdy  = 1'b1;
      we_cnt = 0; clr_cnt = 0; got = 1'b0; got_resp = 8'h00;
      we_data = 32'h0; we_addr = '0;
      for (int c = 0; c < 400 && !got; c++) begin
         @(posedge clk); #1;
         if (rx_rdy_clr) begin clr_cnt++; rx_rdy = 1'b0; end
         if (mem_we) begin we_cnt++; we_data = mem_wdata; we_addr = mem_addr; end
         if (tx_wr_en) begin got = 1'b1; got_resp = tx_din; end
      end
      rx_rdy = 1'b0;
      @(posedge clk); #1;
      if (mem_we) we_cnt++;
      if (rx_rdy_clr) clr_cnt++;
      if (tx_wr_en) we_cnt += 100;
   endtask

   initial begin
      int early;
      int pulses;
      logic [7:0] pd;
      logic [AW-1:0] exp_addr;

      add_str("1234567", 0, 0);
      add(8'h38, 8'h38, 1, 32'h12345678, 1, 0, 0);
      add_str("de\nadBEE", 1, 0);
      add(8'h46, 8'h46, 1, 32'hDEADBEEF, 2, 0, 0);
      add_str("12", 2, 0);
      add(8'h47, 8'h3F, 0, 32'h0, 2, 1, 0);
      add_str("0000001", 2, 1);
      add(8'h33, 8'h33, 1, 32'h00000013, 3, 1, 0);
      add_str("0000000", 3, 1);
      add(8'h34, 8'h34, 1, 32'h00000004, 4, 1, 0);
      add_str("0000000", 4, 1);
      add(8'h35, 8'h21, 0, 32'h0, 4, 1, 0);
      add(8'h58, 8'h58, 0, 32'h0, 0, 0, 0);
      add(8'h41, 8'h41, 0, 32'h0, 0, 0, 0);
      add(8'h2E, 8'h3F, 0, 32'h0, 0, 1, 0);
      add(8'h58, 8'h58, 0, 32'h0, 0, 0, 0);
      add(8'h2E, 8'h4B, 0, 32'h0, 0, 0, 1);
      add(8'h35, 8'h21, 0, 32'h0, 0, 0, 1);
      add(8'h58, 8'h58, 0, 32'h0, 0, 0, 0);

      rst_n = 1'b0; rx_rdy = 1'b0; rx_dout = 8'h00; tx_busy = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_tx_wr_en", tx_wr_en, 0);
      check("rst_mem_we", mem_we, 0);
      check("rst_rx_rdy_clr", rx_rdy_clr, 0);
      check("rst_word_count", word_count, 0);
      check("rst_load_done", load_done, 0);
      check("rst_err", err, 0);
      rst_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         send_byte(vecs[i].b);
         check($sformatf("v%0d_tx_timeout", i), got, 1);
         check($sformatf("v%0d_resp", i), got_resp, vecs[i].resp);
         check($sformatf("v%0d_clr_cnt", i), clr_cnt, 1);
         check($sformatf("v%0d_we_cnt", i), we_cnt, vecs[i].we ? 1 : 0);
         if (vecs[i].we) begin
            exp_addr = (vecs[i].wc > 4) ? 2'd3 : 2'(vecs[i].wc - 1);
            check($sformatf("v%0d_wdata", i), we_data, vecs[i].wd);
            check($sformatf("v%0d_waddr", i), we_addr, exp_addr);
         end
         exp_addr = (vecs[i].wc > 3) ? 2'd3 : 2'(vecs[i].wc);
         check($sformatf("v%0d_word_count", i), word_count, vecs[i].wc);
         check($sformatf("v%0d_mem_addr", i), mem_addr, exp_addr);
         check($sformatf("v%0d_err", i), err, vecs[i].e);
         check($sformatf("v%0d_load_done", i), load_done, vecs[i].done);
         $display("byte %02h -> resp %02h we %0d wc %0d err %0d done %0d",
                  vecs[i].b, got_resp, we_cnt, word_count, err, load_done);
      end

      // Build up nonzero status before the held-busy end-of-load.
      send_byte(8'h47);
      check("pre_bad_resp", got_resp, 8'h3F);
      for (int i = 0; i < 7; i++) send_byte(8'h30);
      send_byte(8'h61);
      check("pre_word_we", we_cnt, 1);
      check("pre_word_data", we_data, 32'h0000000A);
      check("pre_word_count", word_count, 1);

      // End-of-load response held off by a busy transmitter.
      rx_dout = 8'h2E; rx_rdy = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk); #1;
         if (rx_rdy_clr) break;
      end
      check("busy_clr_seen", rx_rdy_clr, 1);
      rx_rdy = 1'b0; tx_busy = 1'b1;
      early = 0;
      for (int c = 0; c < 100; c++) begin
         @(posedge clk); #1;
         if (tx_wr_en) early++;
      end
      check("busy_no_strobe", early, 0);
      tx_busy = 1'b0;
      #1;
      pulses = 0; pd = 8'h00;
      for (int c = 0; c < 10; c++) begin
         if (tx_wr_en) begin pulses++; pd = tx_din; end
         @(posedge clk); #1;
      end
      check("busy_pulses", pulses, 1);
      check("busy_resp", pd, 8'h4B);
      check("busy_load_done", load_done, 1);
      check("busy_err_kept", err, 1);
      $display("held-busy end-of-load: pulses %0d resp %02h", pulses, pd);

      // Asynchronous reset while waiting in TXWAIT.
      rx_dout = 8'h35; rx_rdy = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk); #1;
         if (rx_rdy_clr) break;
      end
      rx_rdy = 1'b0; tx_busy = 1'b1;
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      tx_busy = 1'b0;
      #1;
      check("arst_tx_wr_en", tx_wr_en, 0);
      check("arst_mem_we", mem_we, 0);
      check("arst_rx_rdy_clr", rx_rdy_clr, 0);
      check("arst_err", err, 0);
      check("arst_load_done", load_done, 0);
      check("arst_word_count", word_count, 0);
      check("arst_tx_din", tx_din, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      send_byte(8'h31);
      check("post_rst_resp", got_resp, 8'h31);
      check("post_rst_clr", clr_cnt, 1);
      $display("after async reset: resp %02h", got_resp);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/uart_hex_loader.md
# uart_hex_loader

Controller that sequences the shared UART RX/TX datapath to download a program image over serial. Consumes received bytes via the UART `rdy`/`rdy_clr` handshake and parses ASCII hex into 32-bit words. Writes completed words to instruction memory at an auto-incrementing address, and answers every byte through the UART transmitter with an echo or status character. Sits between the UART instance and the instruction memory, replacing ad-hoc echo logic in the top level.

## Interface
- `ADDR_W`, default 6: instruction memory address width; capacity 2^ADDR_W words.
- `clk`  in  1  system clock, shared with UART.
- `rst_n`  in  1  asynchronous active-low reset.
- `rx_dout`  in  8  received byte from UART.
- `rx_rdy`  in  1  UART byte valid; held high until cleared.
- `rx_rdy_clr`  out  1  one-cycle pulse acknowledging `rx_dout`.
- `tx_din`  out  8  byte to transmit; stable while `tx_wr_en` is high.
- `tx_wr_en`  out  1  one-cycle transmit strobe.
- `tx_busy`  in  1  UART transmitter busy.
- `mem_we`  out  1  one-cycle write strobe.
- `mem_addr`  out  ADDR_W  write address (next free word).
- `mem_wdata`  out  32  assembled word.
- `word_count`  out  ADDR_W+1  words written since last clear.
- `load_done`  out  1  sticky; set by end-of-load command.
- `err`  out  1  sticky; invalid character or overflow.

## Operation
- Byte classes:
  - Hex digits: `0-9`, `A-F`, `a-f`.
  - `X` (0x58): clear.
  - `.` (0x2E): end of load.
  - Ignored: 0x0D, 0x0A, 0x20.
  - Every other byte is invalid.
- Hex digit:
  - Shift the nibble into `mem_wdata` (MSB first) and increment the 3-bit nibble counter. Respond with an echo of the byte.
  - On the 8th nibble: if `word_count < 2^ADDR_W`, pulse `mem_we`, then increment `mem_addr` and `word_count`. Otherwise set `err`, suppress the write, and respond `!` (0x21).
  - The nibble counter wraps to 0 in either case.
- Ignored byte: echo only. No state change; the partial word is retained.
- Invalid byte: respond `?` (0x3F), set `err`, reset the nibble counter. The partial word is discarded.
- `.`:
  - Nibble counter 0: set `load_done`, respond `K` (0x4B).
  - Nibble counter nonzero: treat as invalid.
- `X`: clear the nibble counter, `mem_addr`, `word_count`, `load_done`, `err` and `mem_wdata`. Echo `X`.
- While `load_done`=1, every byte except `X` responds `!` and has no other effect.
- FSM states:
  - IDLE: if `rx_rdy` and `!tx_busy`, latch `rx_dout` and go to DECODE.
  - DECODE: classify the byte, update state, select the response, go to TXWAIT.
  - TXWAIT: when `!tx_busy`, pulse `tx_wr_en` and go to GAP.
  - GAP: one cycle, then IDLE.
- GAP guarantees that `tx_busy` is not sampled in the cycle right after `tx_wr_en`.
- Exactly one response byte per received byte.
- Reset values: all outputs 0; FSM in IDLE; nibble counter 0.

## Timing
- IDLE accepts a byte in cycle N:
  - `rx_rdy_clr`=1 in N+1 only.
  - `mem_we` (if any) =1 in N+2 only, with `mem_addr`/`mem_wdata` valid in the same cycle.
  - `mem_addr` and `word_count` increment in N+3.
- Earliest `tx_wr_en` is N+2, when `tx_busy`=0. It then waits indefinitely while `tx_busy`=1. `tx_din` is valid from N+2 until `tx_wr_en` drops.
- Minimum per-byte turnaround is 4 cycles (IDLE, DECODE, TXWAIT, GAP). `rx_rdy` arriving in any other state is held by the UART and serviced at the next IDLE.
- `rx_rdy` still high in the cycle after `rx_rdy_clr` must not be re-accepted. This is guaranteed because IDLE is reached at N+4 at the earliest.
- `rst_n` low at any time (including TXWAIT or the `mem_we` cycle) forces all outputs to 0 asynchronously. No partial write or strobe completes.
- The `mem_addr` increment saturates at 2^ADDR_W-1 and never wraps. Overflow is reported through `word_count` and `err`.

## Test plan
- Reset: assert `rst_n`=0 mid-TXWAIT → `tx_wr_en`, `mem_we`, `rx_rdy_clr`, `err`, `load_done`, `word_count` = 0 immediately; FSM resumes at IDLE.
- Send `12345678` with `tx_busy` idle → echoes `1`..`8`; single `mem_we` with `mem_addr`=0, `mem_wdata`=0x12345678; then `word_count`=1, `mem_addr`=1.
- Send `de\nadBEEF` → echo of all 9 bytes; one write of 0xDEADBEEF; newline does not disturb the nibble count.
- Send `12G` then `00000013` → third response `?`, `err`=1; next write is 0x00000013 at the following address, with no write for the fragment.
- `ADDR_W`=2: send 5 words → 4 writes at addresses 0..3; 5th word responds `!` on its last digit with no `mem_we`, `err`=1, `word_count`=4.
- Send `.` → `K`, `load_done`=1; then `5` → `!` with no state change; then `X` → echo `X` and all status cleared. Hold `tx_busy`=1 for 100 cycles before the `K` → `tx_wr_en` stays low until release, then a single pulse.
